spi_master_sequencer: RTL
=========================

# spi_master_sequencer

Sequences multi-byte SPI master transactions on top of `serializer_deserializer`. It accepts a command (write count, read count, chip-select hold), streams write bytes in from a valid/ready source, and drives the byte-level `start/stop/write/read` handshake of the serdes. Read bytes go out through a one-entry valid/ready buffer. It sits between the FCB register/FIFO layer and the serdes, in the `Bus_CLK_i` domain.

## Interface
- `LEN_W`, 8: width of the write and read byte counts.
- `TO_W`, 16: width of the watchdog counter; the limit is 2^TO_W−1 cycles.

- `Bus_CLK_i` in 1: single clock; the serdes runs on this clock too.
- `RST_i` in 1: asynchronous, active-high reset.
- `RST_SYNC_i` in 1: synchronous clear; same effect as `RST_i`.
- `cmd_valid_i` in 1: command offer.
- `cmd_ready_o` out 1: command accept.
- `cmd_wr_len_i` in LEN_W: number of bytes to write.
- `cmd_rd_len_i` in LEN_W: number of bytes to read.
- `cmd_hold_cs_i` in 1: 1 = skip the stop, so CS stays asserted.
- `tx_valid_i` in 1, `tx_ready_o` out 1, `tx_data_i` in 8: write byte stream.
- `rx_valid_o` out 1, `rx_ready_i` in 1, `rx_data_o` out 8: read byte stream.
- `done_o` out 1: one-cycle pulse at command end.
- `err_o` out 1: sticky watchdog timeout; cleared on acceptance of the next command.
- `busy_o` out 1: state ≠ IDLE.
- `start_o`, `stop_o`, `write_o`, `read_o` out 1: to serdes `start_i`, `stop_i`, `write_i`, `read_i`.
- `wdata_o` out 8: to serdes `SPI_Write_Data_i`.
- `irq_write_i`, `irq_read_i`, `trnfer_cmplte_i` in 1: from serdes.
- `rdata_i` in 8: from serdes `SPI_Read_Data_o`.

## Operation
**States:** IDLE, LOAD, WR_REQ, WR_REL, RD_WAIT, RD_REQ, RD_REL, STOP_REQ, STOP_REL, DONE.

**Command and write path**
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i`:
  - latch `wr_cnt`, `rd_cnt` and `hold`; clear `err_o`;
  - `wr_cnt`>0 → LOAD; else `rd_cnt`>0 → RD_WAIT; else → DONE (no serdes activity).
- LOAD: `tx_ready_o`=1. On `tx_valid_i`, register `tx_data_i` into `wdata_o` → WR_REQ.
- WR_REQ: `start_o`=`write_o`=1 until `irq_write_i`=1 → WR_REL.
- WR_REL: `start_o`=0. Wait for `irq_write_i`=0, then `wr_cnt`−1:
  - remaining >0 → LOAD;
  - else `rd_cnt`>0 → RD_WAIT;
  - else `hold` → DONE;
  - else → STOP_REQ.

**Read path**
- RD_WAIT: wait for the rx buffer to be empty (`rx_valid_o`=0 or being popped this cycle) → RD_REQ. This is back-pressure: no read is issued into a full buffer.
- RD_REQ: `start_o`=`read_o`=1 until `irq_read_i`=1. On that cycle, load `rdata_i` into `rx_data_o` and set `rx_valid_o` → RD_REL.
- RD_REL: `start_o`=0. Wait for `irq_read_i`=0, then `rd_cnt`−1:
  - remaining >0 → RD_WAIT;
  - else `hold` → DONE;
  - else → STOP_REQ.

**Stop and completion**
- STOP_REQ: `stop_o`=1 until `trnfer_cmplte_i`=1 → STOP_REL.
- STOP_REL: `stop_o`=0. Wait for `trnfer_cmplte_i`=0 → DONE.
- DONE: `done_o`=1 for one cycle → IDLE.

**Signal rules**
- `start_o` and `stop_o` are never high in the same cycle.
- `write_o` and `read_o` are only high together with `start_o`.

**Watchdog**
- The counter resets on every state change and counts only in WR_REQ, WR_REL, RD_REQ, RD_REL, STOP_REQ and STOP_REL.
- On reaching all-ones: set `err_o`, drop `start_o`/`write_o`/`read_o`, and go → STOP_REQ.
- A timeout inside STOP_REQ or STOP_REL → DONE directly; `hold` is ignored.

**Other rules**
- Counts are unsigned. The maximum is 2^LEN_W−1 bytes per direction; the decrement never wraps.
- The rx buffer is independent of state: `rx_valid_o` clears on `rx_ready_i`, and an unread byte survives DONE and IDLE.
- `RST_i` or `RST_SYNC_i` mid-transfer returns the block to IDLE at once; the outstanding transfer is discarded.

## Timing
- Every output resets to 0 except `cmd_ready_o`, which is 1 because the block resets into IDLE.
- All outputs are registered or pure state decodes, with no combinational input-to-output paths, except:
  - `cmd_ready_o` and `tx_ready_o`, which are state decodes;
  - `rx_ready_i` to RD_WAIT, which is combinational inside the block only.
- Command accept → first `start_o`: 2 cycles when `tx_valid_i` is already high (IDLE→LOAD→WR_REQ).
- The per-byte cost is the serdes latency plus 2 handshake cycles; the serdes itself advances only on `Baud_rate_re`.
- `done_o` rises 1 cycle after `trnfer_cmplte_i` falls, or 1 cycle after the last release when `hold`=1.
- Simultaneous `rx_ready_i` pop and new capture in RD_REQ: the new byte wins and `rx_valid_o` stays 1.

## Structure
- `spi_seq_pkg` holds the state enum and the state encodings, so the bench can decode state.
- One sub-module, `spi_seq_watchdog`: counter, clear-on-state-change, timeout flag.
- The rx buffer stays inline.

## Test plan
- **Write only.** Cmd wr_len=3, rd_len=0, hold=0; tx 0xA5, 0x3C, 0xFF → serdes sees three start+write requests with `wdata_o` in that order, one stop, one `done_o`, `err_o`=0.
- **Read with back-pressure.** Cmd wr_len=0, rd_len=2; hold `rx_ready_i`=0 until the second byte is due → the second `start_o` is delayed until the pop; `rx_data_o` equals the serdes bytes (0x5A, 0x81).
- **Hold chip select.** Cmd wr_len=1, rd_len=1, hold=1 → no `stop_o`, serdes CS stays asserted; a following cmd 0/0 with hold=0 → `done_o` with no stop issued.
- **Zero length.** Cmd 0/0 → `done_o` 1 cycle after accept; `start_o`/`stop_o` never pulse.
- **Watchdog.** `irq_write_i` stuck at 0, TO_W=4 → after 15 cycles `err_o`=1, `stop_o` is issued, then `done_o`; the next cmd accept clears `err_o`.
- **Reset mid-read.** Assert `RST_SYNC_i` in RD_REQ → the next cycle is IDLE, all control outputs are 0 and `cmd_ready_o`=1.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI master sequencer: FSM state encoding, the
// registered serdes control bundle and small state decode helpers.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_WR_REQ   = 4'd2,
    ST_WR_REL   = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_RD_REQ   = 4'd5,
    ST_RD_REL   = 4'd6,
    ST_STOP_REQ = 4'd7,
    ST_STOP_REL = 4'd8,
    ST_DONE     = 4'd9
  } state_t;

  typedef struct packed {
    logic start;
    logic stop;
    logic write;
    logic read;
    logic done;
  } ctl_t;

  // Serdes control levels that hold for the whole time a state is occupied.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      ST_WR_REQ:   begin c.start = 1'b1; c.write = 1'b1; end
      ST_RD_REQ:   begin c.start = 1'b1; c.read  = 1'b1; end
      ST_STOP_REQ: c.stop = 1'b1;
      ST_DONE:     c.done = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  // States that wait on the serdes and are therefore guarded by the watchdog.
  function automatic logic wd_active(state_t s);
    return (s == ST_WR_REQ) || (s == ST_WR_REL) || (s == ST_RD_REQ) ||
           (s == ST_RD_REL) || (s == ST_STOP_REQ) || (s == ST_STOP_REL);
  endfunction

endpackage

// File: rtl/spi_master_sequencer_if.sv
// Command, byte-stream and serdes handshake signals of the sequencer.
// master: the side that issues commands and answers as the serdes.
// slave:  the sequencer itself.
interface spi_master_sequencer_if #(
  parameter int LEN_W = 8
) ();
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_wr_len_i;
  logic [LEN_W-1:0] cmd_rd_len_i;
  logic             cmd_hold_cs_i;
  logic             tx_valid_i;
  logic             tx_ready_o;
  logic [7:0]       tx_data_i;
  logic             rx_valid_o;
  logic             rx_ready_i;
  logic [7:0]       rx_data_o;
  logic             done_o;
  logic             err_o;
  logic             busy_o;
  logic             start_o;
  logic             stop_o;
  logic             write_o;
  logic             read_o;
  logic [7:0]       wdata_o;
  logic             irq_write_i;
  logic             irq_read_i;
  logic             trnfer_cmplte_i;
  logic [7:0]       rdata_i;

  modport master (
    output cmd_valid_i, cmd_wr_len_i, cmd_rd_len_i, cmd_hold_cs_i,
           tx_valid_i, tx_data_i, rx_ready_i,
           irq_write_i, irq_read_i, trnfer_cmplte_i, rdata_i,
    input  cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o, done_o, err_o,
           busy_o, start_o, stop_o, write_o, read_o, wdata_o
  );

  modport slave (
    input  cmd_valid_i, cmd_wr_len_i, cmd_rd_len_i, cmd_hold_cs_i,
           tx_valid_i, tx_data_i, rx_ready_i,
           irq_write_i, irq_read_i, trnfer_cmplte_i, rdata_i,
    output cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o, done_o, err_o,
           busy_o, start_o, stop_o, write_o, read_o, wdata_o
  );
endinterface

// File: rtl/spi_seq_watchdog.sv
// Per-state watchdog: counts cycles spent in a serdes-waiting state,
// restarts from zero whenever the state changes, and flags a timeout once
// the count reaches all-ones.
module spi_seq_watchdog
  import spi_seq_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic   Bus_CLK_i,
  input  logic   RST_i,
  input  logic   RST_SYNC_i,
  input  state_t state,
  output logic   timeout
);
  state_t          prev_state;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cur;
  logic            active;

  assign active  = wd_active(state);
  // A state entered this cycle has spent no cycles yet.
  assign cur     = (state != prev_state) ? '0 : cnt;
  assign timeout = active && (cur == '1);

  // Remember the last state and advance the saturating count while it persists.
  always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
    if (RST_i) begin
      prev_state <= ST_IDLE;
      cnt        <= '0;
    end else if (RST_SYNC_i) begin
      prev_state <= ST_IDLE;
      cnt        <= '0;
    end else begin
      prev_state <= state;
      if (!active)         cnt <= '0;
      else if (cur != '1)  cnt <= cur + TO_W'(1);
      else                 cnt <= cur;
    end
  end
endmodule

// File: rtl/spi_master_sequencer.sv
// Multi-byte SPI master transaction sequencer driving the byte-level
// start/stop/write/read handshake of the serdes, with a one-entry rx buffer.
module spi_master_sequencer
  import spi_seq_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int TO_W  = 16
) (
  input logic                   Bus_CLK_i,
  input logic                   RST_i,
  input logic                   RST_SYNC_i,
  spi_master_sequencer_if.slave bus
);
  state_t           state;
  ctl_t             ctl;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] rd_cnt;
  logic             hold;
  logic             err;
  logic             timeout;
  logic [7:0]       wdata;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_free;

  spi_seq_watchdog #(.TO_W(TO_W)) u_wdog (
    .Bus_CLK_i  (Bus_CLK_i),
    .RST_i      (RST_i),
    .RST_SYNC_i (RST_SYNC_i),
    .state      (state),
    .timeout    (timeout)
  );

  // The buffer can take a new byte if it is empty or being popped now.
  assign rx_free = !rx_valid || bus.rx_ready_i;

  // Transaction FSM; serdes controls are registered alongside the state.
  always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
    if (RST_i || RST_SYNC_i) begin
      state  <= ST_IDLE;
      ctl    <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      hold   <= 1'b0;
      err    <= 1'b0;
      wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.cmd_valid_i) begin
          wr_cnt <= bus.cmd_wr_len_i;
          rd_cnt <= bus.cmd_rd_len_i;
          hold   <= bus.cmd_hold_cs_i;
          err    <= 1'b0;
          if (bus.cmd_wr_len_i != '0) begin
            state <= ST_LOAD;    ctl <= ctl_of(ST_LOAD);
          end else if (bus.cmd_rd_len_i != '0) begin
            state <= ST_RD_WAIT; ctl <= ctl_of(ST_RD_WAIT);
          end else begin
            state <= ST_DONE;    ctl <= ctl_of(ST_DONE);
          end
        end
        ST_LOAD: if (bus.tx_valid_i) begin
          wdata <= bus.tx_data_i;
          state <= ST_WR_REQ; ctl <= ctl_of(ST_WR_REQ);
        end
        ST_WR_REQ: if (bus.irq_write_i) begin
          state <= ST_WR_REL; ctl <= ctl_of(ST_WR_REL);
        end else if (timeout) begin
          err <= 1'b1; state <= ST_STOP_REQ; ctl <= ctl_of(ST_STOP_REQ);
        end
        ST_WR_REL: if (!bus.irq_write_i) begin
          if (wr_cnt != '0) wr_cnt <= wr_cnt - LEN_W'(1);
          if (wr_cnt > LEN_W'(1)) begin
            state <= ST_LOAD;     ctl <= ctl_of(ST_LOAD);
          end else if (rd_cnt != '0) begin
            state <= ST_RD_WAIT;  ctl <= ctl_of(ST_RD_WAIT);
          end else if (hold) begin
            state <= ST_DONE;     ctl <= ctl_of(ST_DONE);
          end else begin
            state <= ST_STOP_REQ; ctl <= ctl_of(ST_STOP_REQ);
          end
        end else if (timeout) begin
          err <= 1'b1; state <= ST_STOP_REQ; ctl <= ctl_of(ST_STOP_REQ);
        end
        ST_RD_WAIT: if (rx_free) begin
          state <= ST_RD_REQ; ctl <= ctl_of(ST_RD_REQ);
        end
        ST_RD_REQ: if (bus.irq_read_i) begin
          state <= ST_RD_REL; ctl <= ctl_of(ST_RD_REL);
        end else if (timeout) begin
          err <= 1'b1; state <= ST_STOP_REQ; ctl <= ctl_of(ST_STOP_REQ);
        end
        ST_RD_REL: if (!bus.irq_read_i) begin
          if (rd_cnt != '0) rd_cnt <= rd_cnt - LEN_W'(1);
          if (rd_cnt > LEN_W'(1)) begin
            state <= ST_RD_WAIT;  ctl <= ctl_of(ST_RD_WAIT);
          end else if (hold) begin
            state <= ST_DONE;     ctl <= ctl_of(ST_DONE);
          end else begin
            state <= ST_STOP_REQ; ctl <= ctl_of(ST_STOP_REQ);
          end
        end else if (timeout) begin
          err <= 1'b1; state <= ST_STOP_REQ; ctl <= ctl_of(ST_STOP_REQ);
        end
        ST_STOP_REQ: if (bus.trnfer_cmplte_i) begin
          state <= ST_STOP_REL; ctl <= ctl_of(ST_STOP_REL);
        end else if (timeout) begin
          err <= 1'b1; state <= ST_DONE; ctl <= ctl_of(ST_DONE);
        end
        ST_STOP_REL: if (!bus.trnfer_cmplte_i) begin
          state <= ST_DONE; ctl <= ctl_of(ST_DONE);
        end else if (timeout) begin
          err <= 1'b1; state <= ST_DONE; ctl <= ctl_of(ST_DONE);
        end
        ST_DONE: begin
          state <= ST_IDLE; ctl <= ctl_of(ST_IDLE);
        end
        default: begin
          state <= ST_IDLE; ctl <= ctl_of(ST_IDLE);
        end
      endcase
    end
  end

  // One-entry rx buffer, independent of the FSM; a capture beats a pop.
  always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
    if (RST_i || RST_SYNC_i) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if ((state == ST_RD_REQ) && bus.irq_read_i) begin
      rx_valid <= 1'b1;
      rx_data  <= bus.rdata_i;
    end else if (bus.rx_ready_i) begin
      rx_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready_o = (state == ST_IDLE);
  assign bus.tx_ready_o  = (state == ST_LOAD);
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.start_o     = ctl.start;
  assign bus.stop_o      = ctl.stop;
  assign bus.write_o     = ctl.write;
  assign bus.read_o      = ctl.read;
  assign bus.done_o      = ctl.done;
  assign bus.err_o       = err;
  assign bus.wdata_o     = wdata;
  assign bus.rx_valid_o  = rx_valid;
  assign bus.rx_data_o   = rx_data;
endmodule
